// File: rtl/twiddle_fetch.sv
// Twiddle address generator and output register for a radix-2 FFT: walks every
// stage/butterfly pair, reads the ROM and hands words downstream over valid/ready.
module twiddle_fetch #(
  parameter int WORD_SIZE = 74,
  parameter int LOG2_N    = 8,
  parameter int MEM_SIZE  = 128,
  parameter int ADDR_SIZE = $clog2(MEM_SIZE)
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_start,
  output logic                      o_read_en,
  output logic [ADDR_SIZE-1:0]      o_read_addr,
  input  logic [WORD_SIZE-1:0]      i_read_data,
  output logic [WORD_SIZE-1:0]      o_twiddle,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [$clog2(LOG2_N)-1:0] o_stage,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int SW = $clog2(LOG2_N);
  localparam logic [SW-1:0]        S_LAST = SW'(LOG2_N - 1);
  localparam logic [ADDR_SIZE-1:0] K_LAST = ADDR_SIZE'(MEM_SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state_reg, state_next;
  logic                   start_reg;
  logic [SW-1:0]          s_reg, s_next;
  logic [ADDR_SIZE-1:0]   k_reg, k_next;
  logic [WORD_SIZE-1:0]   twiddle_reg;
  logic [SW-1:0]          stage_reg;
  logic                   valid_reg;

  logic                   load;
  logic                   accept;
  logic                   last_load;
  logic [ADDR_SIZE-1:0]   k_mask;
  logic [SW-1:0]          shift_amt;
  logic [ADDR_SIZE-1:0]   addr_calc;

  assign load      = (state_reg == RUN) && (!valid_reg || i_ready);
  assign accept    = valid_reg && i_ready;
  assign last_load = load && (s_reg == S_LAST) && (k_reg == K_LAST);

  // k mod 2^s: keep only the low s bits of k
  generate
    for (genvar gi = 0; gi < ADDR_SIZE; gi++) begin : g_mask
      assign k_mask[gi] = (int'(s_reg) > gi);
    end
  endgenerate

  assign shift_amt = S_LAST - s_reg;
  assign addr_calc = (k_reg & k_mask) << shift_amt;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_reg) state_next = RUN;
      RUN:     if (last_load) state_next = DRAIN;
      DRAIN:   if (accept)    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_read_en   = 1'b0;
    o_read_addr = '0;
    o_busy      = (state_reg != IDLE);
    o_done      = (state_reg == DONE);
    if (load) begin
      o_read_en   = 1'b1;
      o_read_addr = addr_calc;
    end
  end

  // Stage/butterfly counters; held at zero in IDLE so a new run starts clean
  always_comb begin
    s_next = s_reg;
    k_next = k_reg;
    if (state_reg == IDLE) begin
      s_next = '0;
      k_next = '0;
    end else if (load) begin
      if (k_reg == K_LAST) begin
        k_next = '0;
        s_next = s_reg + 1'b1;
      end else begin
        k_next = k_reg + 1'b1;
      end
    end
  end

  // Start is registered, giving a two-edge latency from request to first load
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      start_reg   <= 1'b0;
      s_reg       <= '0;
      k_reg       <= '0;
      twiddle_reg <= '0;
      stage_reg   <= '0;
      valid_reg   <= 1'b0;
    end else begin
      start_reg <= i_start && (state_reg == IDLE);
      s_reg     <= s_next;
      k_reg     <= k_next;
      if (load) begin
        twiddle_reg <= i_read_data;
        stage_reg   <= s_reg;
        valid_reg   <= 1'b1;
      end else if (accept) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign o_twiddle = twiddle_reg;
  assign o_stage   = stage_reg;
  assign o_valid   = valid_reg;

endmodule

// File: tb/tb_twiddle_fetch.sv
// Scoreboard bench for twiddle_fetch: a reference sequence is queued at start and
// a negedge monitor checks every ROM read and every accepted word against it.
module tb_twiddle_fetch;

  localparam int WS    = 74;
  localparam int LOG2N = 8;
  localparam int MEM   = 128;
  localparam int AW    = 7;
  localparam int SW    = 3;
  localparam int TOTAL = LOG2N * MEM;

  typedef struct packed {
    logic [WS-1:0] tw;
    logic [SW-1:0] st;
  } word_t;

  logic          clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_ready = 1'b1;
  logic          o_read_en;
  logic [AW-1:0] o_read_addr;
  logic [WS-1:0] i_read_data;
  logic [WS-1:0] o_twiddle;
  logic          o_valid;
  logic [SW-1:0] o_stage;
  logic          o_busy;
  logic          o_done;

  logic [WS-1:0] rom [MEM];

  word_t         exp_q[$];
  logic [AW-1:0] addr_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int acc_total = 0;
  int done_cnt = 0;

  bit            final_pending = 0;
  bit            hold_pending = 0;
  logic [WS-1:0] held_tw;
  logic [SW-1:0] held_st;

  always #5 clk = ~clk;

  assign i_read_data = rom[o_read_addr];

  twiddle_fetch dut (
    .i_clk       (clk),
    .i_reset_n   (i_reset_n),
    .i_start     (i_start),
    .o_read_en   (o_read_en),
    .o_read_addr (o_read_addr),
    .i_read_data (i_read_data),
    .o_twiddle   (o_twiddle),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_stage     (o_stage),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: stage s, butterfly k uses twiddle index (k mod 2^s) * 2^(LOG2N-1-s)
  function automatic void push_seq();
    for (int s = 0; s < LOG2N; s++) begin
      for (int k = 0; k < MEM; k++) begin
        int    a;
        word_t w;
        a    = (k % (1 << s)) * (1 << (LOG2N - 1 - s));
        w.tw = rom[a];
        w.st = SW'(s);
        addr_q.push_back(AW'(a));
        exp_q.push_back(w);
      end
    end
  endfunction

  // Monitor: inputs change just after posedge, so negedge sees the values the next edge uses
  always @(negedge clk) begin
    if (!i_reset_n) begin
      final_pending = 0;
      hold_pending  = 0;
    end else begin
      if (o_done) done_cnt++;
      if (final_pending) begin
        chk("done_after_last_accept", o_done, 1);
        final_pending = 0;
      end
      if (hold_pending) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_twiddle", o_twiddle, held_tw);
        chk("hold_stage", o_stage, held_st);
        hold_pending = 0;
      end
      if (o_read_en) begin
        if (addr_q.size() == 0) fail_now("spurious_read");
        else chk("read_addr", o_read_addr, addr_q.pop_front());
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("extra_word");
        end else begin
          word_t w;
          w = exp_q.pop_front();
          chk("word_twiddle", o_twiddle, w.tw);
          chk("word_stage", o_stage, w.st);
          if (exp_q.size() == 0) final_pending = 1;
        end
        acc_total++;
      end
      if (o_valid && !i_ready) begin
        hold_pending = 1;
        held_tw = o_twiddle;
        held_st = o_stage;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_read_en"}, o_read_en, 0);
    chk({tag, "_read_addr"}, o_read_addr, 0);
    chk({tag, "_twiddle"}, o_twiddle, 0);
    chk({tag, "_stage"}, o_stage, 0);
  endtask

  // mode 0: ready high, 1: random ready with a 5-cycle stall in stage 3, 2: ready toggling
  task automatic run_seq(input int mode, input bit abort);
    int            base_acc, base_done, cyc, n, stall_left;
    bit            seen_done, stall_done;
    logic [WS-1:0] h_tw;
    logic [SW-1:0] h_st;
    for (int i = 0; i < MEM; i++) rom[i] = WS'({$urandom, $urandom, $urandom});
    push_seq();
    base_acc  = acc_total;
    base_done = done_cnt;
    @(posedge clk); #1;
    i_start = 1'b1;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    if (mode == 0) begin
      chk("lat_e0_busy", o_busy, 0);
      chk("lat_e0_valid", o_valid, 0);
    end
    cyc = 0; seen_done = 0; stall_done = 0; stall_left = 0;
    while (!seen_done && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (mode == 0 && cyc == 1) begin
        chk("lat_e1_busy", o_busy, 1);
        chk("lat_e1_valid", o_valid, 0);
      end
      if (mode == 0 && cyc == 2) begin
        chk("lat_e2_valid", o_valid, 1);
        chk("lat_e2_stage", o_stage, 0);
      end
      if (o_done) begin
        seen_done = 1;
      end else begin
        n = acc_total - base_acc;
        if (abort && n >= 300) begin
          i_start   = 1'b0;
          i_reset_n = 1'b0;
          exp_q.delete();
          addr_q.delete();
          @(posedge clk); #1;
          check_zero("abort");
          i_reset_n = 1'b1;
          repeat (3) @(posedge clk);
          #1;
          chk("abort_no_done", done_cnt - base_done, 0);
          chk("abort_idle_busy", o_busy, 0);
          return;
        end
        case (mode)
          0: begin
            i_ready = 1'b1;
            i_start = (abort && n == 100);
          end
          1: begin
            if (stall_left > 0) begin
              i_ready = 1'b0;
              #2;
              chk("stall_read_en", o_read_en, 0);
              chk("stall_twiddle", o_twiddle, h_tw);
              chk("stall_stage", o_stage, h_st);
              stall_left--;
            end else if (!stall_done && n >= 444 && o_valid) begin
              stall_done = 1;
              stall_left = 4;
              h_tw = o_twiddle;
              h_st = o_stage;
              i_ready = 1'b0;
              #2;
              chk("stall_in_stage3", o_stage, 3);
              chk("stall_read_en", o_read_en, 0);
            end else begin
              i_ready = ($urandom_range(0, 3) != 0);
            end
          end
          default: i_ready = ((cyc % 2) == 1);
        endcase
      end
    end
    if (!seen_done) begin
      fail_now("timeout_waiting_done");
    end else begin
      chk("done_busy", o_busy, 1);
      chk("queue_empty", exp_q.size(), 0);
      @(posedge clk); #1;
      chk("done_single_pulse", o_done, 0);
      chk("idle_after_done", o_busy, 0);
      chk("done_count", done_cnt - base_done, 1);
      chk("word_count", acc_total - base_acc, TOTAL);
    end
    i_ready = 1'b1;
    i_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MEM; i++) rom[i] = '0;
    i_reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    i_reset_n = 1'b1;
    @(posedge clk); #1;
    $display("txn: full run, ready high");
    run_seq(0, 0);
    $display("txn: random ready with stall in stage 3");
    run_seq(1, 0);
    $display("txn: ready toggling");
    run_seq(2, 0);
    $display("txn: start during run, reset at word 300");
    run_seq(0, 1);
    $display("txn: restart after abort");
    run_seq(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
